// File: rtl/btn_if.sv
// Button conditioning bundle: raw pin in, debounced level and edge pulses out.
// master = the debouncer, slave = the raw-pin source / pulse consumer.
interface btn_if;
    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;

    modport master (
        input  btn_in,
        output btn_level,
        output press_pulse,
        output release_pulse
    );

    modport slave (
        output btn_in,
        input  btn_level,
        input  press_pulse,
        input  release_pulse
    );
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, counter-based debounce FSM,
// registered level/press/release outputs and optional auto-repeat while held.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned BTN_ACTIVE_LOW  = 1,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned HOLD_CYCLES     = 13500000,
    parameter int unsigned REPEAT_CYCLES   = 5400000
) (
    input logic  clk,
    input logic  rst_n,
    btn_if.master bus
);
    localparam int unsigned CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX);
    localparam logic        INACTIVE = (BTN_ACTIVE_LOW != 0);

    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t            state;
    logic              sync1, sync2;
    logic              btn_s;
    logic [CNT_W-1:0]  cnt;
    logic [HOLD_W-1:0] hold;
    logic              rpt_phase;
    logic              level_q, press_q, rel_q;

    // Flops reset to the idle pin level so a held button is seen as a fresh press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= INACTIVE;
            sync2 <= INACTIVE;
        end else begin
            sync1 <= bus.btn_in;
            sync2 <= sync1;
        end
    end

    assign btn_s = sync2 ^ INACTIVE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hold      <= '0;
            rpt_phase <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
        end else begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state     <= PRESSED;
                        press_q   <= 1'b1;
                        level_q   <= 1'b1;
                        hold      <= '0;
                        rpt_phase <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end else if (REPEAT_EN != 0) begin
                        // First repeat waits HOLD_CYCLES, later ones REPEAT_CYCLES
                        if (hold == (rpt_phase ? REP_LAST : HOLD_LAST)) begin
                            press_q   <= 1'b1;
                            hold      <= '0;
                            rpt_phase <= 1'b1;
                        end else begin
                            hold <= hold + 1'b1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state <= PRESSED;
                    end else if (cnt == DB_LAST) begin
                        state     <= IDLE;
                        rel_q     <= 1'b1;
                        level_q   <= 1'b0;
                        hold      <= '0;
                        rpt_phase <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.btn_level     = level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = rel_q;
endmodule
